// File: rtl/song_seq_pkg.sv
// Shared types for the song sequencer: FSM state encoding, ROM entry field slices, end marker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
`define SONG_SEQ_NOTE(data, nw, dw) data[(nw)+(dw)-1:(dw)]
`define SONG_SEQ_DUR(data, dw) data[(dw)-1:0]

package song_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_END   = 3'd4
    } state_t;

    localparam int END_MARKER = 0;

endpackage

// File: rtl/beat_countdown.sv
// Loadable beat down-counter holding the beats left in the current note.
// Latency: load/decrement visible the cycle after; last is combinational on the enabling beat.
// Backpressure: en (beat & play) gates counting; the count saturates at zero.
module beat_countdown
    import song_seq_pkg::*;
#(
    parameter int DUR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             en,
    output logic [DUR_W-1:0] count,
    output logic             last
);

    logic [DUR_W-1:0] count_q;
    logic [DUR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = en && (count_q == DUR_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Steps through one song in the external ROM and times each note in beats; SONG_LOOP_EN restarts the song while play stays high.
// Latency: new_note 2 cycles after FETCH is entered, 3 cycles after the previous note's last beat.
// Backpressure: play=0 freezes the beat count in PLAY; a fetch already under way still completes.
module song_sequencer
    import song_seq_pkg::*;
#(
    parameter int SONG_W = 2,
    parameter int ADDR_W = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     beat,
    output logic [SONG_W+ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]  rom_data,
    output logic [NOTE_W-1:0]        note_out,
    output logic                     new_note,
    output logic                     playing,
    output logic                     song_done
);

    state_t                   state_q, state_d;
    logic [SONG_W-1:0]        song_q, song_d;
    logic [ADDR_W-1:0]        note_idx_q, note_idx_d;
    logic [SONG_W+ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]        note_out_q, note_out_d;
    logic                     new_note_q, new_note_d;
    logic                     playing_q, playing_d;
    logic                     song_done_q, song_done_d;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              is_marker;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_last;
    logic [DUR_W-1:0]  beats_left;

    assign rom_note  = `SONG_SEQ_NOTE(rom_data, NOTE_W, DUR_W);
    assign rom_dur   = `SONG_SEQ_DUR(rom_data, DUR_W);
    assign is_marker = (rom_dur == DUR_W'(END_MARKER));
    assign cnt_load  = (state_q == ST_WAIT) && !is_marker;
    // Beats outside PLAY or while paused are dropped, never queued.
    assign cnt_en    = beat && play && (state_q == ST_PLAY);

    beat_countdown #(.DUR_W(DUR_W)) u_countdown (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (rom_dur),
        .en       (cnt_en),
        .count    (beats_left),
        .last     (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        note_idx_d  = note_idx_q;
        note_out_d  = note_out_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play) begin
                    song_d  = song_sel;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (is_marker) begin
                    state_d = ST_END;
                end else begin
                    note_out_d = rom_note;
                    new_note_d = 1'b1;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (cnt_last) begin
                    if (note_idx_q == '1) begin
                        state_d = ST_END;
                    end else begin
                        note_idx_d = note_idx_q + 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_END: begin
                song_done_d = 1'b1;
                note_out_d  = '0;
                note_idx_d  = '0;
`ifdef SONG_LOOP_EN
                state_d     = play ? ST_FETCH : ST_IDLE;
`else
                state_d     = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // Address register tracks the next song/index so it is already valid during FETCH.
        rom_addr_d = {song_d, note_idx_d};
        playing_d  = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            song_q      <= '0;
            note_idx_q  <= '0;
            rom_addr_q  <= '0;
            note_out_q  <= '0;
            new_note_q  <= 1'b0;
            playing_q   <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            note_idx_q  <= note_idx_d;
            rom_addr_q  <= rom_addr_d;
            note_out_q  <= note_out_d;
            new_note_q  <= new_note_d;
            playing_q   <= playing_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign note_out  = note_out_q;
    assign new_note  = new_note_q;
    assign playing   = playing_q;
    assign song_done = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: 1-cycle ROM model, beat every 32 cycles, event scoreboard.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        beat = 1'b0;
    logic [1:0]  song_sel = 2'd0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_out;
    logic        new_note;
    logic        playing;
    logic        song_done;

    logic [11:0] mem [128];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int beats = 0;
    int last_beat_cyc = 0;
    int prev_dur = 0;

    typedef struct {
        bit is_done;
        int note;
        int dur;
        int lat;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;

    song_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song_sel  (song_sel),
        .beat      (beat),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_out  (note_out),
        .new_note  (new_note),
        .playing   (playing),
        .song_done (song_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= mem[rom_addr];

    initial begin
        int b;
        b = 0;
        forever begin
            @(posedge clk);
            #1;
            b = (b + 1) % 32;
            beat = (b == 0);
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_note(input int n, input int d, input int l);
        sb.push_back('{is_done: 1'b0, note: n, dur: d, lat: l});
    endtask

    task automatic push_done(input int l);
        sb.push_back('{is_done: 1'b1, note: 0, dur: 0, lat: l});
    endtask

    // Expected latency is measured from the cycle of the previous note's last counted beat.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            beats    = 0;
            prev_dur = 0;
        end else begin
            if (playing && play && beat) begin
                beats++;
                last_beat_cyc = cyc;
            end
            if (new_note || song_done) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_event", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("event_kind", int'(song_done), int'(mon_e.is_done));
                    check_eq("note_out", int'(note_out), mon_e.is_done ? 0 : mon_e.note);
                    if (prev_dur > 0) check_eq("beats_per_note", beats, prev_dur);
                    if (mon_e.lat > 0) check_eq("latency", cyc - last_beat_cyc, mon_e.lat);
                    prev_dur = mon_e.is_done ? 0 : mon_e.dur;
                    beats    = 0;
                end
            end
        end
    end

    task automatic wait_note(input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk);
            #2;
            if (new_note && (note_out == 6'(n))) got = 1'b1;
        end
        if (!got) check_eq("note_timeout", n, -1);
    endtask

    task automatic wait_done(input int sel);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(posedge clk);
            #2;
            if (song_done) begin
                play = 1'b0;
                got  = 1'b1;
                check_eq("addr_at_done", int'(rom_addr), sel * 32);
            end
        end
        if (!got) check_eq("done_timeout", 0, 1);
    endtask

    task automatic after_song();
`ifdef SONG_LOOP_EN
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 500 && !empty; i++) begin
            @(posedge clk);
            #2;
            empty = (sb.size() == 0);
        end
        check_eq("loop_restart_seen", int'(empty), 1);
        check_eq("loop_playing", int'(playing), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
`else
        repeat (4) @(posedge clk);
        #2;
        check_eq("idle_playing", int'(playing), 0);
        check_eq("idle_note_out", int'(note_out), 0);
        check_eq("idle_sb_empty", sb.size(), 0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 12'd0;
        for (int i = 0; i < 32; i++) mem[i] = {6'(i + 1), 6'd1};
        mem[32] = {6'd5, 6'd2};
        mem[33] = {6'd9, 6'd1};
        mem[64] = {6'd7, 6'd3};
        mem[65] = {6'd11, 6'd2};
        mem[96] = {6'd20, 6'd1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #2;
        check_eq("rst_rom_addr", int'(rom_addr), 0);
        check_eq("rst_note_out", int'(note_out), 0);
        check_eq("rst_new_note", int'(new_note), 0);
        check_eq("rst_playing", int'(playing), 0);
        check_eq("rst_song_done", int'(song_done), 0);

        // Reset while the fourth note (index 3) of song 0 is playing.
        for (int i = 0; i < 32; i++) push_note(i + 1, 1, (i == 0) ? 0 : 3);
        song_sel = 2'd0;
        play     = 1'b1;
        wait_note(4);
        repeat (5) @(posedge clk);
        #2;
        check_eq("pre_rst_addr", int'(rom_addr), 3);
        check_eq("pre_rst_playing", int'(playing), 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_addr", int'(rom_addr), 0);
        check_eq("mid_rst_note_out", int'(note_out), 0);
        check_eq("mid_rst_playing", int'(playing), 0);
        check_eq("mid_rst_song_done", int'(song_done), 0);
        play = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check_eq("idle_hold_playing", int'(playing), 0);
        check_eq("idle_hold_addr", int'(rom_addr), 0);

        // Full 32-entry song ending by index wrap.
        for (int i = 0; i < 32; i++) push_note(i + 1, 1, (i == 0) ? 0 : 3);
        push_done(2);
`ifdef SONG_LOOP_EN
        push_note(1, 1, 0);
`endif
        song_sel = 2'd0;
        play     = 1'b1;
        wait_done(0);
        after_song();

        // Song 1, with song_sel moved to 2 mid-song.
        push_note(5, 2, 0);
        push_note(9, 1, 3);
        push_done(4);
`ifdef SONG_LOOP_EN
        push_note(5, 2, 0);
`endif
        song_sel = 2'd1;
        play     = 1'b1;
        wait_note(5);
        song_sel = 2'd2;
        wait_note(9);
        check_eq("sel_ignored_addr", int'(rom_addr), 33);
        wait_done(1);
        after_song();

        // Song 2, paused for 100 cycles inside its 3-beat first note.
        push_note(7, 3, 0);
        push_note(11, 2, 3);
        push_done(4);
`ifdef SONG_LOOP_EN
        push_note(7, 3, 0);
`endif
        play = 1'b1;
        wait_note(7);
        repeat (10) @(posedge clk);
        #2;
        check_eq("song2_addr", int'(rom_addr), 64);
        play = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        check_eq("pause_note_out", int'(note_out), 7);
        check_eq("pause_playing", int'(playing), 1);
        check_eq("pause_new_note", int'(new_note), 0);
        play = 1'b1;
        wait_done(2);
        after_song();

        // Song 3, single one-beat note.
        push_note(20, 1, 0);
        push_done(4);
`ifdef SONG_LOOP_EN
        push_note(20, 1, 0);
`endif
        song_sel = 2'd3;
        play     = 1'b1;
        wait_done(3);
        after_song();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
